// File: rtl/gobou_pkg.sv
// gobou_pkg: shared control-bus record, FSM states and default multiplier latency
package gobou_pkg;
   typedef struct packed {logic start, valid, stop;} ctrl_reg;
   typedef enum logic {IDLE, RUN} mac_state;
   localparam int LAT_MUL_DEFAULT = 2;
endpackage

// File: rtl/ctrl_bus.sv
// ctrl_bus: start/valid/stop framing bus between gobou pipeline stages
interface ctrl_bus;
   logic start, valid, stop;
   modport master (output start, valid, stop);
   modport slave (input start, valid, stop);
endinterface

// File: rtl/ctrl_delay.sv
// ctrl_delay: DEPTH-stage shift register of ctrl_reg with asynchronous active-low clear
module ctrl_delay
   import gobou_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic    clk,
   input  logic    xrst,
   input  ctrl_reg d,
   output ctrl_reg q
);
   ctrl_reg sr [DEPTH];
   // shift one stage per cycle; reset flushes every in-flight pulse
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end
   assign q = sr[DEPTH-1];
endmodule

// File: rtl/ctrl_mac.sv
// ctrl_mac: MAC control sequencer (run qualification, accumulator strobes, output framing); optional busy port via CTRL_MAC_BUSY_EN
module ctrl_mac
   import gobou_pkg::*;
#(
   parameter int LAT_MUL = LAT_MUL_DEFAULT
) (
   input  logic clk,
   input  logic xrst,
   ctrl_bus.slave in_ctrl,
   ctrl_bus.master out_ctrl,
`ifdef CTRL_MAC_BUSY_EN
   output logic busy,
`endif
   output logic mac_oe,
   output logic accum_we,
   output logic accum_rst
);
   mac_state state, state_nx;
   logic run;
   ctrl_reg q, dl, od_in, od;
   // run state register
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) state <= IDLE;
      else state <= state_nx;
   end
   // qualification: start always wins; valid/stop only count inside a run
   always_comb begin
      run = (state == RUN);
      q.start = in_ctrl.start;
      q.valid = in_ctrl.valid & run & ~in_ctrl.start;
      q.stop = in_ctrl.stop & run & ~in_ctrl.start;
      state_nx = in_ctrl.start ? RUN : (q.stop ? IDLE : state);
   end
   ctrl_delay #(.DEPTH(LAT_MUL)) u_lat (.clk(clk), .xrst(xrst), .d(q), .q(dl));
   assign od_in = '{start: dl.start, valid: dl.stop, stop: dl.stop};
   ctrl_delay #(.DEPTH(1)) u_out (.clk(clk), .xrst(xrst), .d(od_in), .q(od));
   assign accum_rst = dl.start;
   assign accum_we = dl.valid;
   assign mac_oe = od.stop;
   assign out_ctrl.start = od.start;
   assign out_ctrl.valid = od.valid;
   assign out_ctrl.stop = od.stop;
`ifdef CTRL_MAC_BUSY_EN
   localparam int CW = $clog2(LAT_MUL + 3) + 1;
   logic [CW-1:0] pend;
   // stops accepted but not yet delivered as mac_oe
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) pend <= '0;
      else pend <= pend + CW'(q.stop) - CW'(mac_oe);
   end
   assign busy = run | (pend != '0);
`endif
endmodule

// File: tb/tb_ctrl_mac.sv
// tb_ctrl_mac: table vectors, directed scenarios and randomized runs against a cycle-event model
module tb_ctrl_mac;
   localparam int L = 2;
   localparam int N = 1024;
   localparam int M = N + L + 2;
   logic clk = 0;
   logic xrst = 0;
   ctrl_bus in_b ();
   ctrl_bus out_b ();
   logic mac_oe, accum_we, accum_rst;
   logic busy_s;
`ifdef CTRL_MAC_BUSY_EN
   logic busy;
   assign busy_s = busy;
`else
   assign busy_s = 1'b0;
`endif
   ctrl_mac #(.LAT_MUL(L)) dut (
      .clk(clk),
      .xrst(xrst),
      .in_ctrl(in_b),
      .out_ctrl(out_b),
`ifdef CTRL_MAC_BUSY_EN
      .busy(busy),
`endif
      .mac_oe(mac_oe),
      .accum_we(accum_we),
      .accum_rst(accum_rst)
   );
   always #5 clk = ~clk;
   int checks = 0;
   int failures = 0;
   logic st [N], va [N], sp [N], rs [N];
   logic [3:0] ex [M];
   logic eb [M];
   logic [5:0] act;
   assign act = {accum_rst, accum_we, mac_oe, out_b.start, out_b.valid, out_b.stop};
   typedef struct {logic st, va, sp; logic [3:0] e; logic b;} vec_t;
   vec_t tv [8];

   function automatic logic [5:0] ex6(input logic [3:0] e);
      return {e[3], e[2], e[1], e[0], e[1], e[1]};
   endfunction

   task automatic check(input string nm, input int c, input logic [5:0] a, input logic [5:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s cycle %0d: got {rst,we,oe,ostart,ovalid,ostop}=%b expected %b", nm, c, a, e);
      end
   endtask

   task automatic check_busy(input string nm, input int c, input logic e);
`ifdef CTRL_MAC_BUSY_EN
      check({nm, "_busy"}, c, {5'b0, busy_s}, {5'b0, e});
`endif
   endtask

   task automatic drive(input logic s, input logic v, input logic p);
      in_b.start = s;
      in_b.valid = v;
      in_b.stop = p;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      xrst = 0;
      drive(0, 0, 0);
      @(negedge clk);
      check("reset", -1, act, 6'b0);
      check_busy("reset", -1, 1'b0);
      @(posedge clk);
      #1;
      xrst = 1;
   endtask

   task automatic clear_stim();
      for (int i = 0; i < N; i++) begin
         st[i] = 0; va[i] = 0; sp[i] = 0; rs[i] = 0;
      end
   endtask

   // expected strobes from the event rules: every qualified event lands a fixed number of cycles later
   task automatic build_model(input int n);
      logic in_run;
      logic qs, qv, qp;
      in_run = 0;
      for (int c = 0; c < M; c++) begin
         ex[c] = '0;
         eb[c] = 0;
      end
      for (int t = 0; t < n; t++) begin
         if (rs[t]) begin
            for (int c = t; c < M; c++) begin
               ex[c] = '0;
               eb[c] = 0;
            end
            in_run = 0;
         end else begin
            eb[t] = eb[t] | in_run;
            qs = st[t];
            qv = va[t] & in_run & ~st[t];
            qp = sp[t] & in_run & ~st[t];
            if (qs) begin
               ex[t+L][3] = 1;
               ex[t+L+1][0] = 1;
            end
            if (qv) ex[t+L][2] = 1;
            if (qp) begin
               ex[t+L+1][1] = 1;
               for (int c = t + 1; c <= t + L + 1; c++) eb[c] = 1;
            end
            if (qs) in_run = 1;
            else if (qp) in_run = 0;
         end
      end
   endtask

   task automatic run_seq(input string nm, input int n);
      build_model(n);
      do_reset();
      for (int c = 0; c < n + L + 2; c++) begin
         @(posedge clk);
         #1;
         if (c < n) begin
            xrst = !rs[c];
            drive(st[c], va[c], sp[c]);
         end else begin
            xrst = 1;
            drive(0, 0, 0);
         end
         @(negedge clk);
         check(nm, c, act, ex6(ex[c]));
         check_busy(nm, c, eb[c]);
      end
   endtask

   initial begin
      drive(0, 0, 0);
      // valid/stop outside a run ignored, then an empty run
      tv[0] = '{0, 1, 0, 4'b0000, 0};
      tv[1] = '{0, 1, 1, 4'b0000, 0};
      tv[2] = '{1, 0, 0, 4'b0000, 0};
      tv[3] = '{0, 0, 1, 4'b0000, 1};
      tv[4] = '{0, 0, 0, 4'b1000, 1};
      tv[5] = '{0, 0, 0, 4'b0001, 1};
      tv[6] = '{0, 0, 0, 4'b0010, 1};
      tv[7] = '{0, 0, 0, 4'b0000, 0};
      #12;
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         #1;
         drive(tv[c].st, tv[c].va, tv[c].sp);
         @(negedge clk);
         check("table", c, act, ex6(tv[c].e));
         check_busy("table", c, tv[c].b);
      end
      clear_stim();
      st[2] = 1;
      for (int c = 3; c <= 803; c++) va[c] = 1;
      sp[803] = 1;
      run_seq("nominal", 808);
      rs[50] = 1;
      run_seq("reset_mid_run", 808);
      clear_stim();
      st[2] = 1;
      for (int c = 3; c <= 9; c++) va[c] = 1;
      st[10] = 1;
      for (int c = 11; c <= 14; c++) va[c] = 1;
      sp[14] = 1;
      run_seq("restart", 20);
      clear_stim();
      st[2] = 1;
      for (int c = 3; c <= 5; c++) va[c] = 1;
      sp[5] = 1;
      st[6] = 1;
      for (int c = 7; c <= 8; c++) va[c] = 1;
      sp[8] = 1;
      run_seq("back_to_back", 14);
      for (int r = 0; r < 4; r++) begin
         clear_stim();
         for (int c = 0; c < 300; c++) begin
            st[c] = ($urandom_range(0, 19) == 0);
            va[c] = $urandom_range(0, 1) == 1;
            sp[c] = ($urandom_range(0, 9) == 0);
            rs[c] = ($urandom_range(0, 149) == 0);
         end
         run_seq("random", 300);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
